// File: rtl/load_store_bus_master_if.sv
`default_nettype none
// ============================================================================
//  Module : load_store_bus_master_if
//  Data-bus signal bundle between the load/store initiator and the responder.
//  Rev    : 1.0
// ============================================================================
interface load_store_bus_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_rd;
    logic                  bus_wd;
    logic                  bus_ready;
    logic [1:0]            bus_from_size;
    logic [1:0]            bus_to_size;
    logic                  bus_unsigned;
    logic [ADDR_WIDTH-1:0] bus_addr_out;
    logic [ADDR_WIDTH-1:0] bus_addr_in;
    logic [31:0]           bus_data_in;
    logic [31:0]           bus_data_out;

    modport master (
        output bus_rd, bus_wd, bus_from_size, bus_to_size, bus_unsigned,
               bus_addr_out, bus_addr_in, bus_data_in,
        input  bus_ready, bus_data_out
    );

    modport slave (
        input  bus_rd, bus_wd, bus_from_size, bus_to_size, bus_unsigned,
               bus_addr_out, bus_addr_in, bus_data_in,
        output bus_ready, bus_data_out
    );
endinterface
`default_nettype wire

// File: rtl/load_store_bus_master.sv
`default_nettype none
// ============================================================================
//  Module : load_store_bus_master
//  Single-outstanding RV32I load/store initiator with alignment, illegal-op
//  and bus-timeout detection.
//  Rev    : 1.0
// ============================================================================
module load_store_bus_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,

    input  wire logic                  req_valid,
    output logic                       req_ready,
    input  wire logic                  req_we,
    input  wire logic [2:0]            req_funct3,
    input  wire logic [ADDR_WIDTH-1:0] req_addr,
    input  wire logic [31:0]           req_wdata,

    output logic                       resp_valid,
    output logic [31:0]                resp_rdata,
    output logic                       exc_misaligned,
    output logic                       exc_illegal,
    output logic                       exc_timeout,

    load_store_bus_master_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DATA = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    typedef struct packed {
        logic                  rd;
        logic                  wd;
        logic [1:0]            from_size;
        logic [1:0]            to_size;
        logic                  uns;
        logic [ADDR_WIDTH-1:0] addr_out;
        logic [ADDR_WIDTH-1:0] addr_in;
        logic [31:0]           data_in;
    } bus_drv_t;

    localparam logic [7:0] c_timeout  = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] c_read_lat = 8'(READ_LATENCY);

    state_t   r_state;
    bus_drv_t r_bus;
    logic     r_we;
    logic [7:0] r_count;

    logic [1:0] w_size;
    logic       w_unsigned;
    logic       w_illegal;
    logic       w_misaligned;

    assign bus.bus_rd        = r_bus.rd;
    assign bus.bus_wd        = r_bus.wd;
    assign bus.bus_from_size = r_bus.from_size;
    assign bus.bus_to_size   = r_bus.to_size;
    assign bus.bus_unsigned  = r_bus.uns;
    assign bus.bus_addr_out  = r_bus.addr_out;
    assign bus.bus_addr_in   = r_bus.addr_in;
    assign bus.bus_data_in   = r_bus.data_in;

    always_comb begin
        w_size     = 2'b00;
        w_unsigned = 1'b0;
        w_illegal  = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000:  w_size = 2'b00;
                3'b001:  w_size = 2'b01;
                3'b010:  w_size = 2'b10;
                default: w_illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000:  w_size = 2'b00;
                3'b001:  w_size = 2'b01;
                3'b010:  w_size = 2'b10;
                3'b100: begin
                    w_size     = 2'b00;
                    w_unsigned = 1'b1;
                end
                3'b101: begin
                    w_size     = 2'b01;
                    w_unsigned = 1'b1;
                end
                default: w_illegal = 1'b1;
            endcase
        end
        // Illegal wins, so misalignment is only reported for a legal funct3.
        w_misaligned = !w_illegal &&
                       (((w_size == 2'b01) && req_addr[0]) ||
                        ((w_size == 2'b10) && (req_addr[1:0] != 2'b00)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_bus          <= '0;
            r_we           <= 1'b0;
            r_count        <= 8'd0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            exc_misaligned <= 1'b0;
            exc_illegal    <= 1'b0;
            exc_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    req_ready      <= 1'b1;
                    resp_valid     <= 1'b0;
                    exc_misaligned <= 1'b0;
                    exc_illegal    <= 1'b0;
                    exc_timeout    <= 1'b0;
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_count   <= 8'd0;
                        req_ready <= 1'b0;
                        if (w_illegal || w_misaligned) begin
                            exc_illegal    <= w_illegal;
                            exc_misaligned <= w_misaligned;
                            resp_valid     <= 1'b1;
                            resp_rdata     <= 32'd0;
                            r_state        <= S_RESP;
                        end else begin
                            r_bus.rd        <= !req_we;
                            r_bus.wd        <= req_we;
                            r_bus.from_size <= req_we ? 2'b00 : w_size;
                            r_bus.to_size   <= req_we ? w_size : 2'b00;
                            r_bus.uns       <= w_unsigned;
                            r_bus.addr_out  <= req_we ? '0 : req_addr;
                            r_bus.addr_in   <= req_we ? req_addr : '0;
                            r_bus.data_in   <= req_we ? req_wdata : 32'd0;
                            r_state         <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (bus.bus_ready) begin
                        r_bus <= '0;
                        if (r_we) begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                            r_state    <= S_RESP;
                        end else begin
                            r_count <= c_read_lat;
                            r_state <= S_WAIT_DATA;
                        end
                    end else if (8'(r_count + 8'd1) == c_timeout) begin
                        r_bus       <= '0;
                        exc_timeout <= 1'b1;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= 32'd0;
                        r_state     <= S_RESP;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end

                S_WAIT_DATA: begin
                    if (r_count == 8'd1) begin
                        resp_rdata <= bus.bus_data_out;
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end

                S_RESP: begin
                    resp_valid     <= 1'b0;
                    exc_misaligned <= 1'b0;
                    exc_illegal    <= 1'b0;
                    exc_timeout    <= 1'b0;
                    req_ready      <= 1'b1;
                    r_state        <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
